// File: rtl/knn_pkg.sv
// Shared defaults, slot layout and FSM state encoding for the streaming kNN top-K selector.
package knn_pkg;

  localparam int unsigned SumLenDef = 10;
  localparam int unsigned LblLenDef = 10;
  localparam int unsigned KNumDef   = 5;

  typedef struct packed {
    logic                 vld;
    logic [SumLenDef-1:0] sum;
    logic [LblLenDef-1:0] lbl;
  } slot_t;

  typedef enum logic [0:0] {
    StIdle,
    StDone
  } state_e;

endpackage

// File: rtl/topk_cell.sv
// One slot of the sorted insertion register: keeps its entry, takes the new beat,
// or takes the upstream entry as the list shifts down.
module topk_cell
  import knn_pkg::*;
#(
  parameter int unsigned SumLen = SumLenDef,
  parameter int unsigned LblLen = LblLenDef
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              shift_i,
  input  logic              mode_max_i,
  input  logic [SumLen-1:0] new_sum_i,
  input  logic [LblLen-1:0] new_lbl_i,
  input  logic              up_vld_i,
  input  logic [SumLen-1:0] up_sum_i,
  input  logic [LblLen-1:0] up_lbl_i,
  input  logic              up_better_i,
  output logic              vld_o,
  output logic [SumLen-1:0] sum_o,
  output logic [LblLen-1:0] lbl_o,
  output logic              better_o
);

  typedef struct packed {
    logic              vld;
    logic [SumLen-1:0] sum;
    logic [LblLen-1:0] lbl;
  } cell_slot_t;

  cell_slot_t slot_q, slot_d;

  // A stored entry equal to the new beat stays ahead of it, so earlier beats win ties.
  always_comb begin
    if (!slot_q.vld) begin
      better_o = 1'b0;
    end else if (mode_max_i) begin
      better_o = (slot_q.sum >= new_sum_i);
    end else begin
      better_o = (slot_q.sum <= new_sum_i);
    end
  end

  always_comb begin
    slot_d = slot_q;
    if (clear_i) begin
      slot_d = '0;
    end else if (shift_i && !better_o) begin
      if (up_better_i) begin
        slot_d = '{vld: 1'b1, sum: new_sum_i, lbl: new_lbl_i};
      end else begin
        slot_d = '{vld: up_vld_i, sum: up_sum_i, lbl: up_lbl_i};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign vld_o = slot_q.vld;
  assign sum_o = slot_q.sum;
  assign lbl_o = slot_q.lbl;

endmodule

// File: rtl/knn_topk_stream.sv
// Streaming top-K selector: a chain of KNum insertion cells plus the collect/present FSM.
// Accepts one (sum, label) beat per cycle and presents the sorted K best after the last beat.
module knn_topk_stream
  import knn_pkg::*;
#(
  parameter int unsigned SumLen = SumLenDef,
  parameter int unsigned LblLen = LblLenDef,
  parameter int unsigned KNum   = KNumDef,
  localparam int unsigned CntW  = $clog2(KNum + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [SumLen-1:0]            in_sum_i,
  input  logic [LblLen-1:0]            in_lbl_i,
  input  logic                         in_last_i,
  input  logic                         mode_max_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [KNum-1:0][SumLen-1:0]  out_sum_o,
  output logic [KNum-1:0][LblLen-1:0]  out_lbl_o,
  output logic [CntW-1:0]              out_count_o
);

  state_e            state_q;
  logic [CntW-1:0]   count_q;
  logic              mode_q;
  logic              in_ready_q;
  logic              out_valid_q;

  logic              accept;
  logic              clear;
  logic              mode_eff;

  logic [KNum-1:0]             vld;
  logic [KNum-1:0]             better;
  logic [KNum-1:0][SumLen-1:0] sum;
  logic [KNum-1:0][LblLen-1:0] lbl;

  assign accept = in_valid_i && in_ready_q;
  assign clear  = (state_q == StDone) && out_ready_i;
  // The first beat of a query uses the live mode input; later beats use the latched one.
  assign mode_eff = (count_q == '0) ? mode_max_i : mode_q;

  for (genvar k = 0; k < KNum; k++) begin : g_cell
    logic              up_vld;
    logic [SumLen-1:0] up_sum;
    logic [LblLen-1:0] up_lbl;
    logic              up_better;

    if (k == 0) begin : g_head
      assign up_vld    = 1'b0;
      assign up_sum    = '0;
      assign up_lbl    = '0;
      assign up_better = 1'b1;
    end else begin : g_body
      assign up_vld    = vld[k-1];
      assign up_sum    = sum[k-1];
      assign up_lbl    = lbl[k-1];
      assign up_better = better[k-1];
    end

    topk_cell #(
      .SumLen(SumLen),
      .LblLen(LblLen)
    ) u_cell (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (clear),
      .shift_i    (accept),
      .mode_max_i (mode_eff),
      .new_sum_i  (in_sum_i),
      .new_lbl_i  (in_lbl_i),
      .up_vld_i   (up_vld),
      .up_sum_i   (up_sum),
      .up_lbl_i   (up_lbl),
      .up_better_i(up_better),
      .vld_o      (vld[k]),
      .sum_o      (sum[k]),
      .lbl_o      (lbl[k]),
      .better_o   (better[k])
    );
  end

  logic unused_better;
  assign unused_better = better[KNum-1];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      count_q     <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (count_q != CntW'(KNum)) begin
              count_q <= count_q + CntW'(1);
            end
            mode_q <= mode_eff;
            if (in_last_i) begin
              state_q     <= StDone;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        StDone: begin
          if (out_ready_i) begin
            state_q     <= StIdle;
            count_q     <= '0;
            mode_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Empty slots read as the worst possible value for the active mode.
  always_comb begin
    for (int k = 0; k < KNum; k++) begin
      out_sum_o[k] = vld[k] ? sum[k] : (mode_q ? '0 : '1);
      out_lbl_o[k] = vld[k] ? lbl[k] : '0;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_count_o = count_q;

endmodule

// File: tb/tb_knn_topk_stream.sv
// Self-checking bench for knn_topk_stream (KNum=3): directed table, corner sequences,
// and random queries scored against a stable-sort reference model.
module tb_knn_topk_stream;

  localparam int unsigned SumLen = 10;
  localparam int unsigned LblLen = 10;
  localparam int unsigned KNum   = 3;
  localparam int unsigned CntW   = $clog2(KNum + 1);
  localparam int          NVec   = 8;

  typedef logic [0:KNum-1][SumLen-1:0] ksum_t;
  typedef logic [0:KNum-1][LblLen-1:0] klbl_t;

  typedef struct packed {
    logic [2:0]          n;
    logic                mx;
    logic [0:4][9:0]     s;
    logic [0:4][9:0]     l;
    ksum_t               es;
    klbl_t               el;
    logic [CntW-1:0]     ec;
  } vec_t;

  logic                        clk;
  logic                        rst_n;
  logic                        in_valid;
  logic                        in_ready;
  logic [SumLen-1:0]           in_sum;
  logic [LblLen-1:0]           in_lbl;
  logic                        in_last;
  logic                        mode_max;
  logic                        out_valid;
  logic                        out_ready;
  logic [KNum-1:0][SumLen-1:0] out_sum;
  logic [KNum-1:0][LblLen-1:0] out_lbl;
  logic [CntW-1:0]             out_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [SumLen-1:0] q_sum[$];
  logic [LblLen-1:0] q_lbl[$];
  vec_t              vecs[NVec];

  knn_topk_stream #(
    .SumLen(SumLen),
    .LblLen(LblLen),
    .KNum  (KNum)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_sum_i   (in_sum),
    .in_lbl_i   (in_lbl),
    .in_last_i  (in_last),
    .mode_max_i (mode_max),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_sum_o  (out_sum),
    .out_lbl_o  (out_lbl),
    .out_count_o(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [0:4][9:0] p5(input int a, input int b, input int c, input int d,
                                          input int e);
    logic [0:4][9:0] r;
    r[0] = a[9:0]; r[1] = b[9:0]; r[2] = c[9:0]; r[3] = d[9:0]; r[4] = e[9:0];
    return r;
  endfunction

  function automatic ksum_t p3(input int a, input int b, input int c);
    ksum_t r;
    r[0] = a[9:0]; r[1] = b[9:0]; r[2] = c[9:0];
    return r;
  endfunction

  // Reference: pick the best remaining beat K times; strict compare keeps the earliest on ties.
  task automatic ref_model(input bit mx, output ksum_t es, output klbl_t el, output int ec);
    bit used[$];
    int n = q_sum.size();
    for (int i = 0; i < n; i++) used.push_back(1'b0);
    for (int k = 0; k < KNum; k++) begin
      es[k] = mx ? '0 : '1;
      el[k] = '0;
    end
    ec = (n < KNum) ? n : KNum;
    for (int k = 0; k < ec; k++) begin
      int best = -1;
      for (int i = 0; i < n; i++) begin
        if (!used[i] && (best < 0 || (mx ? (q_sum[i] > q_sum[best])
                                         : (q_sum[i] < q_sum[best])))) best = i;
      end
      used[best] = 1'b1;
      es[k] = q_sum[best];
      el[k] = q_lbl[best];
    end
  endtask

  // Mode is driven only on the first beat; later beats carry the opposite value.
  task automatic send_beats(input bit mx, input bit with_last);
    int stalls = 0;
    int i = 0;
    while (i < q_sum.size() && stalls < 20) begin
      bit acc;
      in_valid = 1'b1;
      in_sum   = q_sum[i];
      in_lbl   = q_lbl[i];
      in_last  = with_last && (i == q_sum.size() - 1);
      mode_max = (i == 0) ? mx : ~mx;
      acc      = in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      else stalls++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("input stalls", stalls, 0);
  endtask

  task automatic expect_result(input string name, input ksum_t es, input klbl_t el,
                               input int ec);
    int waited = 0;
    check({name, " out_valid latency"}, out_valid, 1);
    while (!out_valid && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    for (int k = 0; k < KNum; k++) begin
      check($sformatf("%s sum[%0d]", name, k), out_sum[k], es[k]);
      check($sformatf("%s lbl[%0d]", name, k), out_lbl[k], el[k]);
    end
    check({name, " count"}, out_count, ec);
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " release in_ready"}, in_ready, 1);
    check({name, " release out_valid"}, out_valid, 0);
    check({name, " release count"}, out_count, 0);
  endtask

  task automatic load_vec(input int v);
    q_sum = {};
    q_lbl = {};
    for (int i = 0; i < int'(vecs[v].n); i++) begin
      q_sum.push_back(vecs[v].s[i]);
      q_lbl.push_back(vecs[v].l[i]);
    end
  endtask

  initial begin
    ksum_t es;
    klbl_t el;
    int    ec;

    vecs[0] = '{n: 5, mx: 0, s: p5(7, 3, 9, 1, 5), l: p5(1, 2, 3, 4, 5),
                es: p3(1, 3, 5), el: p3(4, 2, 5), ec: 3};
    vecs[1] = '{n: 5, mx: 1, s: p5(7, 3, 9, 1, 5), l: p5(1, 2, 3, 4, 5),
                es: p3(9, 7, 5), el: p3(3, 1, 5), ec: 3};
    vecs[2] = '{n: 4, mx: 0, s: p5(4, 4, 4, 4, 0), l: p5(1, 2, 3, 4, 0),
                es: p3(4, 4, 4), el: p3(1, 2, 3), ec: 3};
    vecs[3] = '{n: 2, mx: 0, s: p5(8, 2, 0, 0, 0), l: p5(1, 2, 0, 0, 0),
                es: p3(2, 8, 1023), el: p3(2, 1, 0), ec: 2};
    vecs[4] = '{n: 1, mx: 1, s: p5(6, 0, 0, 0, 0), l: p5(7, 0, 0, 0, 0),
                es: p3(6, 0, 0), el: p3(7, 0, 0), ec: 1};
    vecs[5] = '{n: 4, mx: 1, s: p5(5, 9, 5, 9, 0), l: p5(1, 2, 3, 4, 0),
                es: p3(9, 9, 5), el: p3(2, 4, 1), ec: 3};
    vecs[6] = '{n: 3, mx: 0, s: p5(1023, 0, 1023, 0, 0), l: p5(1, 2, 3, 0, 0),
                es: p3(0, 1023, 1023), el: p3(2, 1, 3), ec: 3};
    vecs[7] = '{n: 2, mx: 1, s: p5(3, 1, 0, 0, 0), l: p5(6, 8, 0, 0, 0),
                es: p3(3, 1, 0), el: p3(6, 8, 0), ec: 2};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_lbl    = '0;
    in_last   = 1'b0;
    mode_max  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 1);
    check("reset count", out_count, 0);
    for (int k = 0; k < KNum; k++) begin
      check($sformatf("reset sum[%0d]", k), out_sum[k], 1023);
      check($sformatf("reset lbl[%0d]", k), out_lbl[k], 0);
    end

    for (int v = 0; v < NVec; v++) begin
      load_vec(v);
      send_beats(vecs[v].mx, 1'b1);
      expect_result($sformatf("vec%0d", v), vecs[v].es, vecs[v].el, int'(vecs[v].ec));
      release_result($sformatf("vec%0d", v));
    end

    // Backpressure: result must hold and input must be refused while out_ready is low.
    load_vec(0);
    send_beats(1'b0, 1'b1);
    expect_result("bp", vecs[0].es, vecs[0].el, 3);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_sum   = SumLen'($urandom_range(0, 1023));
      in_lbl   = LblLen'($urandom_range(0, 1023));
      in_last  = 1'b1;
      mode_max = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check($sformatf("bp c%0d in_ready", c), in_ready, 0);
      check($sformatf("bp c%0d out_valid", c), out_valid, 1);
      check($sformatf("bp c%0d sum[0]", c), out_sum[0], 1);
      check($sformatf("bp c%0d lbl[2]", c), out_lbl[2], 5);
      check($sformatf("bp c%0d count", c), out_count, 3);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    release_result("bp");
    load_vec(3);
    send_beats(1'b0, 1'b1);
    expect_result("bp next", vecs[3].es, vecs[3].el, 2);
    release_result("bp next");

    // Reset in the middle of a max-mode query; the next query starts clean in min mode.
    q_sum = {10'd11, 10'd22};
    q_lbl = {10'd1, 10'd2};
    send_beats(1'b1, 1'b0);
    check("midrst pre count", out_count, 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst out_valid", out_valid, 0);
    check("midrst count", out_count, 0);
    check("midrst in_ready", in_ready, 1);
    check("midrst sum[0]", out_sum[0], 1023);
    q_sum = {10'd6};
    q_lbl = {10'd9};
    send_beats(1'b0, 1'b1);
    expect_result("midrst q", p3(6, 1023, 1023), p3(9, 0, 0), 1);
    release_result("midrst q");

    // Random queries: one 64-beat back-to-back run, then short ones with narrow sums for ties.
    for (int r = 0; r < 6; r++) begin
      bit mx;
      int n;
      n  = (r == 0) ? 64 : $urandom_range(1, 12);
      mx = 1'($urandom_range(0, 1));
      q_sum = {};
      q_lbl = {};
      for (int i = 0; i < n; i++) begin
        q_sum.push_back((r % 2 == 0) ? SumLen'($urandom_range(0, 1023))
                                     : SumLen'($urandom_range(0, 7)));
        q_lbl.push_back(LblLen'($urandom_range(0, 1023)));
      end
      ref_model(mx, es, el, ec);
      send_beats(mx, 1'b1);
      expect_result($sformatf("rand%0d", r), es, el, ec);
      release_result($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
